// File: rtl/mux4_scan_ctrl.sv
// Select sequencer and in-system checker for a 4:1 mux: drives a word onto the
// mux data inputs, walks sel 0..3, and rebuilds the word from the mux output.
module mux4_scan_ctrl #(
    parameter int unsigned DWELL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [3:0] mux_i,
    output logic [1:0] mux_sel,
    input  logic       mux_y,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       out_err,
    output logic       busy
);

    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [3:0]    cap, cap_n;
    logic [3:0]    mux_i_n;
    logic [1:0]    mux_sel_n;
    logic          out_valid_n;
    logic [3:0]    out_data_n;
    logic          out_err_n;
    logic          dwell_end;

    assign dwell_end = (dcnt == DW'(DWELL - 1));
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            dcnt      <= '0;
            cap       <= '0;
            mux_i     <= '0;
            mux_sel   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            state     <= state_n;
            dcnt      <= dcnt_n;
            cap       <= cap_n;
            mux_i     <= mux_i_n;
            mux_sel   <= mux_sel_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_err   <= out_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        dcnt_n      = dcnt;
        cap_n       = cap;
        mux_i_n     = mux_i;
        mux_sel_n   = mux_sel;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_err_n   = out_err;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    mux_i_n   = in_data;
                    mux_sel_n = '0;
                    dcnt_n    = '0;
                    cap_n     = '0;
                    state_n   = SCAN;
                end
            end
            SCAN: begin
                if (!dwell_end) begin
                    dcnt_n = dcnt + 1'b1;
                end else begin
                    cap_n[mux_sel] = mux_y;
                    dcnt_n         = '0;
                    if (mux_sel != 2'd3) begin
                        mux_sel_n = mux_sel + 2'd1;
                    end else begin
                        // cap_n already holds mux_y in bit 3, i.e. {mux_y, cap[2:0]}
                        out_data_n  = cap_n;
                        out_err_n   = (cap_n != mux_i);
                        out_valid_n = 1'b1;
                        state_n     = DONE;
                    end
                end
            end
            DONE: begin
                out_valid_n = 1'b0;
                mux_sel_n   = '0;
                state_n     = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
